// File: rtl/synth_pkg.sv
// Shared constants for the voice synthesis chain: ADSR state encoding,
// envelope full scale and default datapath widths.
package synth_pkg;

  localparam int ENV_W_DEF    = 16;
  localparam int SAMPLE_W_DEF = 16;

  localparam logic [ENV_W_DEF-1:0] ENV_MAX = '1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/env_scale_mult.sv
// Two-stage signed sample x unsigned gain multiplier; output is the product
// arithmetically shifted down by the gain width (truncation, no rounding).
module env_scale_mult #(
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 16
) (
  input  logic                       clk,
  input  logic                       i_reset,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic        [GAIN_W-1:0]   i_gain,
  output logic signed [SAMPLE_W-1:0] o_sample
);

  logic signed [SAMPLE_W-1:0]      r_sample;
  logic        [GAIN_W-1:0]        r_gain;
  logic signed [SAMPLE_W+GAIN_W:0] w_product;

  // Zero-extending the gain keeps it positive in the signed multiply.
  assign w_product = r_sample * $signed({1'b0, r_gain});

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its source.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_sample <= '0;
      r_gain   <= '0;
      o_sample <= '0;
    end else begin
      r_sample <= i_sample;
      r_gain   <= i_gain;
      o_sample <= SAMPLE_W'(w_product >>> GAIN_W);
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator, stepped on i_tick, scaling the sine
// stream by the current level. Define ADSR_EXP_RELEASE_EN for an exponential-like release.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int ENV_W    = ENV_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       clk,
  input  logic                       i_reset,
  input  logic                       i_tick,
  input  logic                       i_gate,
  input  logic        [ENV_W-1:0]    i_attack_step,
  input  logic        [ENV_W-1:0]    i_decay_step,
  input  logic        [ENV_W-1:0]    i_sustain_level,
  input  logic        [ENV_W-1:0]    i_release_step,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic signed [SAMPLE_W-1:0] o_sample,
  output logic        [ENV_W-1:0]    o_env,
  output logic                       o_active
);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [ENV_W-1:0] r_env;
  logic [ENV_W-1:0] w_env_nxt;
  logic             r_active;

  logic [ENV_W:0]   w_att_sum;
  logic [ENV_W-1:0] w_att_env;
  logic [ENV_W-1:0] w_dec_room;
  logic [ENV_W:0]   w_rel_dec;

  assign w_att_sum  = {1'b0, r_env} + {1'b0, i_attack_step};
  assign w_att_env  = w_att_sum[ENV_W] ? '1 : w_att_sum[ENV_W-1:0];
  assign w_dec_room = r_env - i_sustain_level;

`ifdef ADSR_EXP_RELEASE_EN
  assign w_rel_dec = {1'b0, r_env >> 4} + {1'b0, i_release_step};
`else
  assign w_rel_dec = {1'b0, i_release_step};
`endif

  // A gate change only moves the state; the level resumes stepping on the
  // following tick, from wherever it was.
  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would infer latches.
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    case (r_state)
      ST_IDLE: begin
        w_env_nxt = '0;
        if (i_gate) w_state_nxt = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!i_gate) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_env_nxt = w_att_env;
          if (&w_att_env) w_state_nxt = ST_DECAY;
        end
      end
      ST_DECAY: begin
        if (!i_gate) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_env <= i_sustain_level || i_decay_step >= w_dec_room) begin
          w_env_nxt   = i_sustain_level;
          w_state_nxt = ST_SUSTAIN;
        end else begin
          w_env_nxt = r_env - i_decay_step;
        end
      end
      ST_SUSTAIN: begin
        if (!i_gate) w_state_nxt = ST_RELEASE;
        else         w_env_nxt   = i_sustain_level;
      end
      ST_RELEASE: begin
        if (i_gate) begin
          w_state_nxt = ST_ATTACK;
        end else if (w_rel_dec >= {1'b0, r_env}) begin
          w_env_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_env_nxt = r_env - w_rel_dec[ENV_W-1:0];
        end
      end
      default: begin
        w_env_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_env    <= '0;
      r_active <= 1'b0;
    end else if (i_tick) begin
      r_state  <= w_state_nxt;
      r_env    <= w_env_nxt;
      r_active <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_env    = r_env;
  assign o_active = r_active;

  env_scale_mult #(
    .SAMPLE_W (SAMPLE_W),
    .GAIN_W   (ENV_W)
  ) u_scale (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_sample (i_sample),
    .i_gain   (r_env),
    .o_sample (o_sample)
  );

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed ADSR/multiplier scenarios
// followed by randomized gate/tick/step traffic against a behavioural model.
module tb_adsr_envelope;
  import synth_pkg::*;

  logic               clk = 1'b0;
  logic               i_reset;
  logic               i_tick;
  logic               i_gate;
  logic        [15:0] i_attack_step;
  logic        [15:0] i_decay_step;
  logic        [15:0] i_sustain_level;
  logic        [15:0] i_release_step;
  logic signed [15:0] i_sample;
  wire  signed [15:0] o_sample;
  wire         [15:0] o_env;
  wire                o_active;

  always #5 clk = ~clk;

  adsr_envelope #(.ENV_W(16), .SAMPLE_W(16)) dut (
    .clk             (clk),
    .i_reset         (i_reset),
    .i_tick          (i_tick),
    .i_gate          (i_gate),
    .i_attack_step   (i_attack_step),
    .i_decay_step    (i_decay_step),
    .i_sustain_level (i_sustain_level),
    .i_release_step  (i_release_step),
    .i_sample        (i_sample),
    .o_sample        (o_sample),
    .o_env           (o_env),
    .o_active        (o_active)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_samples = 1'b1;
  bit check_en     = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_ATT, P_DEC, P_SUS, P_REL} phase_t;
  phase_t m_phase = P_IDLE;
  int     m_env    = 0;
  int     m_active = 0;
  int     m_pipe1  = 0;
  int     m_out    = 0;

  function automatic int scale(input int s, input int e);
    longint p;
    p = longint'(s) * longint'(e);
    return int'(p >>> 16);
  endfunction

  task automatic model_tick();
    int a, d, s, r, dec;
    a = int'(i_attack_step);
    d = int'(i_decay_step);
    s = int'(i_sustain_level);
    r = int'(i_release_step);
    case (m_phase)
      P_IDLE: begin
        m_env = 0;
        if (i_gate) m_phase = P_ATT;
      end
      P_ATT: begin
        if (!i_gate) m_phase = P_REL;
        else begin
          m_env = m_env + a;
          if (m_env >= int'(ENV_MAX)) begin
            m_env   = int'(ENV_MAX);
            m_phase = P_DEC;
          end
        end
      end
      P_DEC: begin
        if (!i_gate) m_phase = P_REL;
        else if (m_env - d <= s) begin
          m_env   = s;
          m_phase = P_SUS;
        end else m_env = m_env - d;
      end
      P_SUS: begin
        if (!i_gate) m_phase = P_REL;
        else m_env = s;
      end
      P_REL: begin
        if (i_gate) m_phase = P_ATT;
        else begin
`ifdef ADSR_EXP_RELEASE_EN
          dec = r + (m_env / 16);
`else
          dec = r;
`endif
          m_env = m_env - dec;
          if (m_env <= 0) begin
            m_env   = 0;
            m_phase = P_IDLE;
          end
        end
      end
      default: m_phase = P_IDLE;
    endcase
    m_active = (m_phase != P_IDLE) ? 1 : 0;
  endtask

  always @(posedge clk) begin
    if (i_reset) begin
      m_phase  = P_IDLE;
      m_env    = 0;
      m_active = 0;
      m_pipe1  = 0;
      m_out    = 0;
    end else begin
      m_out   = m_pipe1;
      m_pipe1 = scale(int'(i_sample), m_env);
      if (i_tick) model_tick();
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_env",    longint'(o_env),    longint'(m_env));
      check("model_active", longint'(o_active), longint'(m_active));
      check("model_sample", longint'(o_sample), longint'(m_out));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    if (rand_samples) i_sample = 16'($urandom);
  endtask

  task automatic tick_expect(input string name, input int exp_env);
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    check(name, longint'(o_env), longint'(exp_env));
    step();
    step();
    step();
  endtask

  function automatic logic [15:0] pick_step();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(1, 16'h0200));
      2:       return 16'($urandom_range(16'h0200, 16'h4000));
      default: return 16'($urandom);
    endcase
  endfunction

  int att_exp [10] = '{'h0000, 'h4000, 'h8000, 'hC000, 'hFFFF,
                       'hEFFF, 'hDFFF, 'hCFFF, 'hC000, 'hC000};

  initial begin
    i_reset         = 1'b1;
    i_tick          = 1'b0;
    i_gate          = 1'b0;
    i_attack_step   = 16'h0;
    i_decay_step    = 16'h0;
    i_sustain_level = 16'h0;
    i_release_step  = 16'h0;
    i_sample        = 16'sd0;

    step();
    check_en = 1'b1;
    step();
    check("reset_env",    longint'(o_env),    0);
    check("reset_active", longint'(o_active), 0);
    check("reset_sample", longint'(o_sample), 0);
    i_reset = 1'b0;

    // Gate low: nothing moves regardless of the sample stream.
    for (int i = 0; i < 4; i++) tick_expect("idle_env", 0);
    check("idle_active", longint'(o_active), 0);
    check("idle_sample", longint'(o_sample), 0);

    // Attack -> decay -> sustain.
    i_attack_step   = 16'h4000;
    i_decay_step    = 16'h1000;
    i_sustain_level = 16'hC000;
    i_release_step  = 16'h4000;
    i_gate          = 1'b1;
    for (int i = 0; i < 10; i++) tick_expect($sformatf("ads_env_%0d", i), att_exp[i]);
    check("ads_active", longint'(o_active), 1);

    // Multiplier corners, using live sustain tracking to set the level.
    i_sustain_level = 16'hFFFF;
    tick_expect("sus_track_max", 'hFFFF);
    rand_samples = 1'b0;
    i_sample = 16'sd32767;
    step();
    i_sample = 16'sh8000;
    step();
    check("mul_full_pos", longint'(o_sample), 32766);
    i_sample = 16'sd0;
    step();
    check("mul_full_neg", longint'(o_sample), -32768);
    i_sustain_level = 16'h8000;
    tick_expect("sus_track_half", 'h8000);
    i_sample = 16'sd1000;
    step();
    step();
    check("mul_half", longint'(o_sample), 500);
    rand_samples = 1'b1;
    i_sustain_level = 16'hC000;
    tick_expect("sus_track_back", 'hC000);

    // Release from sustain.
    i_gate = 1'b0;
    tick_expect("rel_entry", 'hC000);
`ifdef ADSR_EXP_RELEASE_EN
    tick_expect("rel_1", 'h7400);
    tick_expect("rel_2", 'h2CC0);
`else
    tick_expect("rel_1", 'h8000);
    tick_expect("rel_2", 'h4000);
`endif
    tick_expect("rel_3", 'h0000);
    check("rel_active", longint'(o_active), 0);

    // Retrigger during release continues from the current level.
    i_gate = 1'b1;
    tick_expect("rt_start", 'h0000);
    tick_expect("rt_att1", 'h4000);
    tick_expect("rt_att2", 'h8000);
    i_gate = 1'b0;
    tick_expect("rt_rel_entry", 'h8000);
`ifdef ADSR_EXP_RELEASE_EN
    tick_expect("rt_rel", 'h3800);
    i_gate = 1'b1;
    tick_expect("rt_hold", 'h3800);
    tick_expect("rt_cont", 'h7800);
`else
    tick_expect("rt_rel", 'h4000);
    i_gate = 1'b1;
    tick_expect("rt_hold", 'h4000);
    tick_expect("rt_cont", 'h8000);
`endif
    check("rt_active", longint'(o_active), 1);

    // Reset mid-attack with streaming samples.
    i_reset = 1'b1;
    step();
    check("midrst_env",    longint'(o_env),    0);
    check("midrst_active", longint'(o_active), 0);
    check("midrst_sample", longint'(o_sample), 0);
    i_reset = 1'b0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      i_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0)  i_gate = ~i_gate;
      if ($urandom_range(0, 149) == 0) i_attack_step   = pick_step();
      if ($urandom_range(0, 149) == 0) i_decay_step    = pick_step();
      if ($urandom_range(0, 149) == 0) i_release_step  = pick_step();
      if ($urandom_range(0, 99) == 0)  i_sustain_level = 16'($urandom);
      i_reset = ($urandom_range(0, 999) == 0);
      step();
    end
    i_tick  = 1'b0;
    i_reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
